// File: rtl/seq_hit_logger_pkg.sv
// Shared defaults for the hit logger and the detector bench.
package seq_pkg;

  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef logic [TS_W-1:0] ts_t;

endpackage

// File: rtl/seq_hit_logger_fifo.sv
// Synchronous first-word-fall-through FIFO; head data is gated to 0 when empty.
module hit_fifo #(
  parameter int W     = seq_pkg::TS_W,
  parameter int DEPTH = seq_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clr,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps detector flags into a FIFO; keeps a saturating hit count and sticky overflow.
module seq_hit_logger #(
  parameter int TS_W  = seq_pkg::TS_W,
  parameter int DEPTH = seq_pkg::DEPTH,
  parameter int CNT_W = seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag,
  input  logic             clr,
  input  logic             rd_en,
  output logic [TS_W-1:0]  rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             overflow
);

  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_hit;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  assign w_push = flag & ~clr;
  assign w_pop  = rd_en & ~clr;
  assign w_drop = w_push & full & ~rd_en;

  // Free-running; clr deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_hit <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (flag && (r_hit != '1)) r_hit <= r_hit + CNT_W'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  hit_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (clr),
    .i_din   (r_ts),
    .o_dout  (rd_data),
    .o_empty (empty),
    .o_full  (full)
  );

  assign hit_cnt  = r_hit;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_hit_logger.sv
// Bench: queue-based reference model, per-cycle compare, and directed literal scenarios.
module tb_seq_hit_logger;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flag = 1'b0;
  logic clr = 1'b0;
  logic rd_en = 1'b0;

  logic [15:0] rd_data;
  logic        empty, full, overflow;
  logic [7:0]  hit_cnt;
  logic [3:0]  n_rd_data;
  logic        n_empty, n_full, n_overflow;
  logic [7:0]  n_hit_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_hit_logger u_dut (
    .clk(clk), .rst(rst), .flag(flag), .clr(clr), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full),
    .hit_cnt(hit_cnt), .overflow(overflow)
  );

  seq_hit_logger #(.TS_W(4), .DEPTH(4), .CNT_W(8)) u_nar (
    .clk(clk), .rst(rst), .flag(flag), .clr(clr), .rd_en(rd_en),
    .rd_data(n_rd_data), .empty(n_empty), .full(n_full),
    .hit_cnt(n_hit_cnt), .overflow(n_overflow)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of timestamps plus plain counters.
  int mq[$];
  int m_ts = 0;
  int m_hit = 0;
  bit m_ovf = 1'b0;
  bit m_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ts = 0;
      m_hit = 0;
      m_ovf = 1'b0;
    end else begin
      if (clr) begin
        mq.delete();
        m_hit = 0;
        m_ovf = 1'b0;
      end else begin
        m_drop = flag && (mq.size() == 4) && !rd_en;
        if (flag && m_hit < 255) m_hit++;
        if (m_drop) m_ovf = 1'b1;
        if (rd_en && mq.size() != 0) void'(mq.pop_front());
        if (flag && !m_drop) mq.push_back(m_ts);
      end
      m_ts = (m_ts + 1) & 16'hFFFF;
    end
  end

  always @(negedge clk) begin
    int head;
    head = (mq.size() != 0) ? mq[0] : 0;
    chk("rd_data",    rd_data,    head);
    chk("empty",      empty,      mq.size() == 0);
    chk("full",       full,       mq.size() == 4);
    chk("hit_cnt",    hit_cnt,    m_hit);
    chk("overflow",   overflow,   m_ovf);
    chk("n_rd_data",  n_rd_data,  head & 15);
    chk("n_empty",    n_empty,    mq.size() == 0);
    chk("n_full",     n_full,     mq.size() == 4);
    chk("n_hit_cnt",  n_hit_cnt,  m_hit);
    chk("n_overflow", n_overflow, m_ovf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic wait_ts(input int v);
    int k = 0;
    while (m_ts != v && k < 200) begin
      step();
      k++;
    end
    if (m_ts != v) chk("wait_ts_timeout", m_ts, v);
  endtask

  task automatic pulse_at(input int v);
    wait_ts(v);
    flag = 1'b1;
    step();
    flag = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input int v);
    chk(nm, rd_data, v);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #10;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // single pulse
    pulse_at(5);
    chk("single_empty", empty, 0);
    chk("single_data", rd_data, 5);
    chk("single_hit", hit_cnt, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("single_pop_empty", empty, 1);
    chk("single_pop_data", rd_data, 0);

    // fill and overflow
    do_reset();
    pulse_at(10);
    pulse_at(13);
    pulse_at(16);
    chk("fill_not_full", full, 0);
    pulse_at(19);
    chk("fill_full", full, 1);
    chk("fill_ovf0", overflow, 0);
    pulse_at(22);
    chk("fill_ovf1", overflow, 1);
    chk("fill_hit5", hit_cnt, 5);
    pop_expect("fill_pop0", 10);
    pop_expect("fill_pop1", 13);
    pop_expect("fill_pop2", 16);
    pop_expect("fill_pop3", 19);
    chk("fill_empty", empty, 1);

    // simultaneous push and pop at full
    do_reset();
    pulse_at(10);
    pulse_at(13);
    pulse_at(16);
    pulse_at(19);
    wait_ts(30);
    flag = 1'b1;
    rd_en = 1'b1;
    step();
    flag = 1'b0;
    rd_en = 1'b0;
    chk("sim_ovf", overflow, 0);
    chk("sim_full", full, 1);
    pop_expect("sim_pop0", 13);
    pop_expect("sim_pop1", 16);
    pop_expect("sim_pop2", 19);
    pop_expect("sim_pop3", 30);
    chk("sim_empty", empty, 1);

    // 4-bit timestamp wrap on the narrow instance
    do_reset();
    pulse_at(15);
    pulse_at(17);
    chk("wrap_a", n_rd_data, 15);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("wrap_b", n_rd_data, 1);
    chk("wrap_wide_b", rd_data, 17);

    // hit counter saturation
    do_reset();
    flag = 1'b1;
    rd_en = 1'b1;
    repeat (300) step();
    flag = 1'b0;
    rd_en = 1'b0;
    chk("sat_hit", hit_cnt, 255);
    chk("sat_n_hit", n_hit_cnt, 255);
    chk("sat_ovf", overflow, 0);

    // clr overrides a same-cycle flag
    do_reset();
    for (int v = 2; v <= 6; v++) pulse_at(v);
    chk("clr_pre_ovf", overflow, 1);
    pop_expect("clr_pop0", 2);
    pop_expect("clr_pop1", 3);
    wait_ts(20);
    clr = 1'b1;
    flag = 1'b1;
    step();
    clr = 1'b0;
    flag = 1'b0;
    chk("clr_empty", empty, 1);
    chk("clr_hit", hit_cnt, 0);
    chk("clr_ovf", overflow, 0);
    flag = 1'b1;
    step();
    flag = 1'b0;
    chk("clr_ts_cont", rd_data, 21);
    chk("clr_hit1", hit_cnt, 1);

    // async reset between edges
    do_reset();
    pulse_at(2);
    pulse_at(3);
    pulse_at(4);
    chk("arst_pre_hit", hit_cnt, 3);
    chk("arst_pre_empty", empty, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_data", rd_data, 0);
    chk("arst_hit", hit_cnt, 0);
    chk("arst_full", full, 0);
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b1;
    step();
    step();
    flag = 1'b0;
    chk("arst_restart_empty", empty, 0);
    pop_expect("arst_ts0", 0);
    pop_expect("arst_ts1", 1);
    chk("arst_drained", empty, 1);

    // randomized traffic against the model
    do_reset();
    repeat (1500) begin
      flag  = ($urandom % 3) == 0;
      rd_en = ($urandom % 2) == 0;
      clr   = ($urandom % 64) == 0;
      step();
    end
    flag = 1'b0;
    rd_en = 1'b0;
    clr = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
